// File: rtl/password_checker.sv
// PS/2 scan-code password checker: make-code decode, 5-key entry, ENTER compare.
// Optional `PWD_LOCKOUT_EN: lock out all input once the fail count saturates.
module password_checker #(
  parameter logic [39:0] PASSWORD = 40'h1D262E4D31,
  parameter int          MAX_FAIL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  output logic       key_tick,
  output logic [7:0] key_code,
  output logic [2:0] digit_count,
  output logic       correct,
  output logic [1:0] Alarma_Vent
);

  localparam logic [1:0] MAXF = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
`ifdef PWD_LOCKOUT_EN
    EXT_BRK,
    LOCK
`else
    EXT_BRK
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        tick_q, tick_d;
  logic [7:0]  code_q, code_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        corr_q, corr_d;
  logic [1:0]  alm_q, alm_d;
  logic        held_q, held_d;
  logic [7:0]  hcode_q, hcode_d;
  logic        ovf_q, ovf_d;
  logic [39:0] keys_q, keys_d;
  logic        match;
  logic        accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      code_q  <= 8'h00;
      cnt_q   <= 3'd0;
      corr_q  <= 1'b0;
      alm_q   <= 2'd0;
      held_q  <= 1'b0;
      hcode_q <= 8'h00;
      ovf_q   <= 1'b0;
      keys_q  <= 40'h0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      corr_q  <= corr_d;
      alm_q   <= alm_d;
      held_q  <= held_d;
      hcode_q <= hcode_d;
      ovf_q   <= ovf_d;
      keys_q  <= keys_d;
    end
  end

  // A make code is accepted unless it repeats the key still held down.
  assign accept = rx_done_tick && (state_q == IDLE)
               && (dout != 8'hF0) && (dout != 8'hE0)
               && !(held_q && (dout == hcode_q));

  assign match = (cnt_q == 3'd5) && !ovf_q && (keys_q == PASSWORD);

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    code_d  = code_q;
    cnt_d   = cnt_q;
    corr_d  = corr_q;
    alm_d   = alm_q;
    held_d  = held_q;
    hcode_d = hcode_q;
    ovf_d   = ovf_q;
    keys_d  = keys_q;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (dout == 8'hF0)      state_d = BRK;
          else if (dout == 8'hE0) state_d = EXT;
        end
        BRK: begin
          if (dout != 8'hF0) begin
            held_d  = 1'b0;
            state_d = IDLE;
          end
        end
        EXT:     state_d = (dout == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    if (accept) begin
      tick_d  = 1'b1;
      code_d  = dout;
      held_d  = 1'b1;
      hcode_d = dout;
      corr_d  = 1'b0;
      if (dout == 8'h5A) begin
        corr_d = match;
        cnt_d  = 3'd0;
        ovf_d  = 1'b0;
        if (match)             alm_d = 2'd0;
        else if (alm_q < MAXF) alm_d = alm_q + 2'd1;
`ifdef PWD_LOCKOUT_EN
        if (!match && alm_d == MAXF) state_d = LOCK;
`endif
      end else if (dout == 8'h66) begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      end else if (cnt_q < 3'd5) begin
        case (cnt_q)
          3'd0:    keys_d[39:32] = dout;
          3'd1:    keys_d[31:24] = dout;
          3'd2:    keys_d[23:16] = dout;
          3'd3:    keys_d[15:8]  = dout;
          default: keys_d[7:0]   = dout;
        endcase
        cnt_d = cnt_q + 3'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign key_tick    = tick_q;
  assign key_code    = code_q;
  assign digit_count = cnt_q;
  assign correct     = corr_q;
  assign Alarma_Vent = alm_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed vector bench for password_checker.
// Build with +define+PWD_LOCKOUT_EN to exercise the lockout variant.
module tb_password_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] dout = 8'h00;
  logic       key_tick;
  logic [7:0] key_code;
  logic [2:0] digit_count;
  logic       correct;
  logic [1:0] Alarma_Vent;

  int total = 0;
  int bad   = 0;

  password_checker dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .key_tick     (key_tick),
    .key_code     (key_code),
    .digit_count  (digit_count),
    .correct      (correct),
    .Alarma_Vent  (Alarma_Vent)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    logic [7:0] b;
    logic       t;
    logic [7:0] c;
    logic [2:0] n;
    logic       co;
    logic [1:0] a;
  } vec_t;

  vec_t vq[$];

  function automatic logic [14:0] obs();
    return {key_tick, key_code, digit_count, correct, Alarma_Vent};
  endfunction

  task automatic chk(input string nm, input logic [14:0] exp);
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, obs(), exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dout = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    dout = 8'hXX;
  endtask

  // Reset lands between clock edges; outputs must clear before any edge.
  task automatic do_rst(input string nm);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk(nm, 15'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input logic [7:0] b, input logic t,
                     input logic [7:0] c, input logic [2:0] n,
                     input logic co, input logic [1:0] a);
    vq.push_back('{1'b0, b, t, c, n, co, a});
  endtask

  task automatic addr();
    vq.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0});
  endtask

  logic [7:0] seq6[6];
  logic [7:0] pw[5];
  logic [1:0] alm_e;
  bit         locked;

  initial begin
    seq6 = '{8'h1D, 8'h26, 8'h2E, 8'h4D, 8'h31, 8'h22};
    pw   = '{8'h1D, 8'h26, 8'h2E, 8'h4D, 8'h31};

    // correct password with break codes
    addr();
    add(8'h1D,1,8'h1D,1,0,0); add(8'hF0,0,8'h1D,1,0,0);
    add(8'h1D,0,8'h1D,1,0,0); add(8'h26,1,8'h26,2,0,0);
    add(8'hF0,0,8'h26,2,0,0); add(8'h26,0,8'h26,2,0,0);
    add(8'h2E,1,8'h2E,3,0,0); add(8'hF0,0,8'h2E,3,0,0);
    add(8'h2E,0,8'h2E,3,0,0); add(8'h4D,1,8'h4D,4,0,0);
    add(8'hF0,0,8'h4D,4,0,0); add(8'h4D,0,8'h4D,4,0,0);
    add(8'h31,1,8'h31,5,0,0); add(8'hF0,0,8'h31,5,0,0);
    add(8'h31,0,8'h31,5,0,0); add(8'h5A,1,8'h5A,0,1,0);
    add(8'hF0,0,8'h5A,0,1,0); add(8'h5A,0,8'h5A,0,1,0);
    // typematic repeat
    addr();
    add(8'h1D,1,8'h1D,1,0,0); add(8'h1D,0,8'h1D,1,0,0);
    add(8'h1D,0,8'h1D,1,0,0); add(8'hF0,0,8'h1D,1,0,0);
    add(8'h1D,0,8'h1D,1,0,0);
    // no breaks, repeated 4D, short entry fails
    addr();
    add(8'h1D,1,8'h1D,1,0,0); add(8'h26,1,8'h26,2,0,0);
    add(8'h2E,1,8'h2E,3,0,0); add(8'h4D,1,8'h4D,4,0,0);
    add(8'h4D,0,8'h4D,4,0,0); add(8'h5A,1,8'h5A,0,0,1);
    // extended keys interleaved, then backspace
    addr();
    add(8'h1D,1,8'h1D,1,0,0); add(8'hF0,0,8'h1D,1,0,0);
    add(8'h1D,0,8'h1D,1,0,0); add(8'hE0,0,8'h1D,1,0,0);
    add(8'h75,0,8'h1D,1,0,0); add(8'h26,1,8'h26,2,0,0);
    add(8'hF0,0,8'h26,2,0,0); add(8'h26,0,8'h26,2,0,0);
    add(8'hE0,0,8'h26,2,0,0); add(8'hF0,0,8'h26,2,0,0);
    add(8'h75,0,8'h26,2,0,0); add(8'h2E,1,8'h2E,3,0,0);
    add(8'hF0,0,8'h2E,3,0,0); add(8'h2E,0,8'h2E,3,0,0);
    add(8'h4D,1,8'h4D,4,0,0); add(8'hF0,0,8'h4D,4,0,0);
    add(8'h4D,0,8'h4D,4,0,0); add(8'h31,1,8'h31,5,0,0);
    add(8'hF0,0,8'h31,5,0,0); add(8'h31,0,8'h31,5,0,0);
    add(8'h5A,1,8'h5A,0,1,0); add(8'h26,1,8'h26,1,0,0);
    add(8'h66,1,8'h66,0,0,0); add(8'h66,0,8'h66,0,0,0);
    add(8'h66,0,8'h66,0,0,0); add(8'hF0,0,8'h66,0,0,0);
    add(8'h66,0,8'h66,0,0,0); add(8'h66,1,8'h66,0,0,0);
    // reset with pending F0 prefix
    addr();
    add(8'h1D,1,8'h1D,1,0,0); add(8'h26,1,8'h26,2,0,0);
    add(8'hF0,0,8'h26,2,0,0);
    addr();
    add(8'h26,1,8'h26,1,0,0);

    foreach (vq[i]) begin
      if (vq[i].r) begin
        do_rst($sformatf("rst_v%0d", i));
      end else begin
        send(vq[i].b);
        chk($sformatf("vec%0d_%h", i, vq[i].b),
            {vq[i].t, vq[i].c, vq[i].n, vq[i].co, vq[i].a});
      end
    end

    // six keys (overflow) then ENTER, four rounds, then the password
    do_rst("rst_fail");
    alm_e  = 2'd0;
    locked = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) begin
        send(seq6[i]);
        chk($sformatf("r%0d_k%0d", k, i),
            {~locked, locked ? 8'h5A : seq6[i],
             locked ? 3'd0 : 3'((i < 5) ? i + 1 : 5),
             1'b0, alm_e});
      end
      if (!locked && alm_e < 2'd3) alm_e = alm_e + 2'd1;
      send(8'h5A);
      chk($sformatf("r%0d_ent", k),
          {~locked, 8'h5A, 3'd0, 1'b0, alm_e});
`ifdef PWD_LOCKOUT_EN
      if (alm_e == 2'd3) locked = 1'b1;
`endif
    end
    for (int i = 0; i < 5; i++) begin
      send(pw[i]);
      chk($sformatf("pw_k%0d", i),
          {~locked, locked ? 8'h5A : pw[i],
           locked ? 3'd0 : 3'(i + 1), 1'b0, alm_e});
    end
    send(8'h5A);
    if (locked) chk("pw_ent", {1'b0, 8'h5A, 3'd0, 1'b0, 2'd3});
    else        chk("pw_ent", {1'b1, 8'h5A, 3'd0, 1'b1, 2'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/password_checker.md
PASSWORD_CHECKER -- requirements
Module: password_checker

Interface
REQ-001 SHALL have parameter PASSWORD, default 40'h1D262E4D31, holding five make codes; the first key is in bits [39:32] ("w","3","5","P","N").
REQ-002 SHALL have parameter MAX_FAIL, default 3, the failed-attempt count at which the alarm saturates.
REQ-003 SHALL have port clk, input, 1 bit: system clock, with all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_done_tick, input, 1 bit: one-cycle strobe from the PS/2 byte receiver.
REQ-006 SHALL have port dout, input, 8 bits: received scan-code byte, valid while rx_done_tick=1.
REQ-007 SHALL have port key_tick, output, 1 bit: one-cycle strobe for each accepted make code.
REQ-008 SHALL have port key_code, output, 8 bits: last accepted make code.
REQ-009 SHALL have port digit_count, output, 3 bits: number of stored characters, 0..5.
REQ-010 SHALL have port correct, output, 1 bit: level signal meaning the last ENTER matched PASSWORD.
REQ-011 SHALL have port Alarma_Vent, output, 2 bits: failed-attempt count, saturating at MAX_FAIL.

Function
REQ-012 SHALL use a decoder FSM with states IDLE, BRK (0xF0 seen), EXT (0xE0 seen), EXT_BRK (0xE0 then 0xF0 seen), plus LOCK when the configuration macro is defined.
REQ-013 SHALL change FSM state only on cycles where rx_done_tick=1.
REQ-014 IDLE transitions SHALL be: 0xF0 -> BRK; 0xE0 -> EXT; any other byte is a make code, processed per REQ-017..022, state stays IDLE.
REQ-015 BRK SHALL discard the next non-0xF0 byte as a release, clear the held flag, and return to IDLE; a repeated 0xF0 stays in BRK.
REQ-016 EXT SHALL go to EXT_BRK on 0xF0 and otherwise discard the byte and return to IDLE; EXT_BRK SHALL discard the next byte and return to IDLE, so extended keys are fully ignored.
REQ-017 A make code equal to the held code while the held flag=1 SHALL be ignored (typematic repeat); otherwise it SHALL be accepted, set the held flag, and load the held code.
REQ-018 An accepted make code SHALL pulse key_tick and update key_code on the cycle after rx_done_tick (latency 1).
REQ-019 On an accepted code other than 0x5A or 0x66: if digit_count<5, SHALL store it at index digit_count and increment digit_count; if digit_count=5, SHALL discard it and set an internal overflow flag.
REQ-020 On accepted 0x66 (backspace), SHALL decrement digit_count if it is >0, with no wrap at 0; the overflow flag is unchanged.
REQ-021 On accepted 0x5A (ENTER), a match SHALL require digit_count=5, overflow=0, and all five stored codes equal to PASSWORD.
REQ-022 ENTER evaluation SHALL give: match -> correct=1 and Alarma_Vent=0; mismatch -> correct=0 and Alarma_Vent+1 saturating at MAX_FAIL; in both cases digit_count=0 and overflow=0, all on the cycle after the ENTER rx_done_tick.
REQ-023 correct SHALL stay high until the next accepted make code of any kind, which clears it on the same cycle as key_tick.
REQ-024 Bytes arriving while rx_done_tick=0 SHALL be ignored.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 When rst=0, SHALL set immediately, without waiting for a clock: FSM=IDLE, key_tick=0, key_code=8'h00, digit_count=0, correct=0, Alarma_Vent=0, held flag=0, overflow=0, stored codes=8'h00.
REQ-027 Reset asserted mid-sequence SHALL discard partial entries and any pending F0/E0 prefix; the first byte after release is decoded from IDLE.

Configuration
REQ-028 With PWD_LOCKOUT_EN defined, reaching Alarma_Vent=MAX_FAIL SHALL enter LOCK, where all bytes are ignored, key_tick=0, correct=0, and Alarma_Vent is held; only rst exits LOCK.
REQ-029 With PWD_LOCKOUT_EN undefined, LOCK SHALL NOT exist, input keeps being accepted at saturation, and a correct entry clears Alarma_Vent.

Verification
REQ-030 Bytes 1D,F0,1D,26,F0,26,2E,F0,2E,4D,F0,4D,31,F0,31,5A,F0,5A -> six key_tick pulses, digit_count 1..5 then 0, correct=1 one cycle after the 5A tick, Alarma_Vent=0.
REQ-031 Bytes 1D,1D,1D,F0,1D (typematic) -> exactly one key_tick, digit_count=1.
REQ-032 Bytes 1D,26,2E,4D,4D,5A without break codes -> second 4D ignored, digit_count=4 at ENTER, correct=0, Alarma_Vent=1.
REQ-033 Six characters then ENTER, repeated three times -> Alarma_Vent 1,2,3 then stays 3; with PWD_LOCKOUT_EN, a following correct sequence -> no key_tick, correct=0.
REQ-034 Bytes E0,75,E0,F0,75 interleaved within the correct password -> no key_tick for them, correct=1 at ENTER; also 26,66,66,66 -> digit_count 1,0,0,0.
REQ-035 rst pulsed low after 1D,26 and the F0 prefix -> all outputs zero asynchronously; a following 26 is accepted as a make code, digit_count=1.
